// File: rtl/cond_unit.sv
// Conditional-execution unit: stored NZCV flags, condition check, gated PC/reg/mem write strobes.
// Latency: strobes and CondEx are combinational (0 cycles); flags update on the rising clk edge.
// Backpressure: none, one instruction is accepted every cycle; optional counters under COND_PERF_EN.
module cond_unit #(
   parameter int         CNT_W    = 16,
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Valid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondEx,
   input  logic             PerfClr,
   output logic [CNT_W-1:0] InstrCnt,
   output logic [CNT_W-1:0] SkipCnt,
   output logic [CNT_W-1:0] BrCnt
);

   logic [3:0] flags_q;
   logic       cond_pass;
   logic       n_f, z_f, c_f, v_f;

   assign n_f = flags_q[3];
   assign z_f = flags_q[2];
   assign c_f = flags_q[1];
   assign v_f = flags_q[0];

   // Evaluate the condition field against the flags left by earlier instructions.
   always_comb begin
      cond_pass = 1'b0;
      case (Cond)
         4'b0000: cond_pass = z_f;
         4'b0001: cond_pass = ~z_f;
         4'b0010: cond_pass = c_f;
         4'b0011: cond_pass = ~c_f;
         4'b0100: cond_pass = n_f;
         4'b0101: cond_pass = ~n_f;
         4'b0110: cond_pass = v_f;
         4'b0111: cond_pass = ~v_f;
         4'b1000: cond_pass = c_f & ~z_f;
         4'b1001: cond_pass = ~c_f | z_f;
         4'b1010: cond_pass = (n_f == v_f);
         4'b1011: cond_pass = (n_f != v_f);
         4'b1100: cond_pass = ~z_f & (n_f == v_f);
         4'b1101: cond_pass = z_f | (n_f != v_f);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Reset is folded in so no strobe escapes while the unit is held in reset.
   assign CondEx   = Valid & cond_pass & ~reset;
   assign PCSrc    = PCS  & CondEx;
   assign RegWrite = RegW & CondEx;
   assign MemWrite = MemW & CondEx;
   assign Flags    = flags_q;

   // Write the N,Z and C,V halves independently, only for executed instructions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= FLAG_RST;
      end else if (CondEx) begin
         if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
         if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

`ifdef COND_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] instr_q, skip_q, br_q;

   // Saturating event counters; a clear wins over any increment in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q <= '0;
         skip_q  <= '0;
         br_q    <= '0;
      end else if (PerfClr) begin
         instr_q <= '0;
         skip_q  <= '0;
         br_q    <= '0;
      end else if (Valid) begin
         if (instr_q != CNT_MAX)           instr_q <= instr_q + CNT_ONE;
         if (!CondEx && skip_q != CNT_MAX) skip_q  <= skip_q + CNT_ONE;
         if (PCSrc && br_q != CNT_MAX)     br_q    <= br_q + CNT_ONE;
      end
   end

   assign InstrCnt = instr_q;
   assign SkipCnt  = skip_q;
   assign BrCnt    = br_q;
`else
   logic unused_perfclr;

   assign unused_perfclr = PerfClr;
   assign InstrCnt       = '0;
   assign SkipCnt        = '0;
   assign BrCnt          = '0;
`endif

endmodule
